// File: rtl/bilinear_interp_pkg.sv
// Shared types and constant helpers for the bilinear interpolator datapath.
// Struct field widths follow the default pixel/weight widths of the top.
package bilinear_interp_pkg;

    localparam int PIX_W  = 8;
    localparam int FRAC_W = 4;

    // Weight value that represents 1.0 for an F-bit fraction.
    function automatic int FRAC_ONE(input int f);
        return 1 << f;
    endfunction

    // Rounding offset for the final >>2F normalisation (half rounds up).
    function automatic int ROUND_HALF(input int f);
        return 1 << (2 * f - 1);
    endfunction

    typedef struct packed {
        logic [PIX_W-1:0] p00;
        logic [PIX_W-1:0] p01;
        logic [PIX_W-1:0] p10;
        logic [PIX_W-1:0] p11;
    } pix_quad_t;

    typedef struct packed {
        logic [FRAC_W-1:0] fx;
        logic [FRAC_W-1:0] fy;
    } frac_pair_t;

endpackage

// File: rtl/bilinear_interp_lerp_stage.sv
// One registered linear blend a*(ONE-w)+b*w with valid pass-through.
// Result is W+F bits wide, which holds the full-scale product exactly.
module lerp_stage
    import bilinear_interp_pkg::*;
#(
    parameter int W = 8,
    parameter int F = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           i_valid,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [F-1:0]   i_w,
    output logic           o_valid,
    output logic [W+F-1:0] o_res
);
    localparam int RW = W + F;

    logic [RW-1:0] w_wb;
    logic [RW-1:0] w_wa;
    logic [RW-1:0] w_a;
    logic [RW-1:0] w_b;
    logic [RW-1:0] w_sum;

    logic          r_valid;
    logic [RW-1:0] r_res;

    assign w_wb  = RW'(i_w);
    assign w_wa  = RW'(FRAC_ONE(F)) - w_wb;
    assign w_a   = RW'(i_a);
    assign w_b   = RW'(i_b);
    assign w_sum = w_a * w_wa + w_b * w_wb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (en) begin
            r_valid <= i_valid;
            r_res   <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_res   = r_res;

endmodule

// File: rtl/bilinear_interp.sv
// Four-stage bilinear interpolator: input register, horizontal blends,
// vertical blend, then round/background select into the output register.
module bilinear_interp
    import bilinear_interp_pkg::*;
#(
    parameter int DATA_Width = PIX_W,
    parameter int FRAC_Width = FRAC_W,
    parameter int BG_VALUE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  in_oob,
    input  logic [DATA_Width-1:0] p00,
    input  logic [DATA_Width-1:0] p01,
    input  logic [DATA_Width-1:0] p10,
    input  logic [DATA_Width-1:0] p11,
    input  logic [FRAC_Width-1:0] frac_x,
    input  logic [FRAC_Width-1:0] frac_y,
    output logic                  out_valid,
    output logic [DATA_Width-1:0] out_pixel
);
    localparam int HW   = DATA_Width + FRAC_Width;
    localparam int ACCW = DATA_Width + 2 * FRAC_Width;

    // S1: captured inputs
    pix_quad_t             r_s1_quad;
    frac_pair_t            r_s1_frac;
    logic                  r_s1_valid;
    logic                  r_s1_oob;

    // S2: horizontal blends plus the side-band that must travel with them
    logic [HW-1:0]         w_top;
    logic [HW-1:0]         w_bot;
    logic                  w_top_valid;
    logic                  w_bot_valid;
    logic                  w_s2_valid;
    logic [FRAC_Width-1:0] r_s2_fy;
    logic                  r_s2_oob;

    // S3: vertical blend
    logic [ACCW-1:0]       w_acc;
    logic                  w_s3_valid;
    logic                  r_s3_oob;

    // S4: output
    logic [ACCW-1:0]       w_rnd;
    logic [DATA_Width-1:0] w_pix;
    logic                  r_out_valid;
    logic [DATA_Width-1:0] r_out_pixel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_quad  <= '0;
            r_s1_frac  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_oob   <= 1'b0;
        end else if (en) begin
            r_s1_quad  <= {p00, p01, p10, p11};
            r_s1_frac  <= {frac_x, frac_y};
            r_s1_valid <= in_valid;
            r_s1_oob   <= in_oob;
        end
    end

    lerp_stage #(.W(DATA_Width), .F(FRAC_Width)) u_lerp_top (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_valid (r_s1_valid),
        .i_a     (r_s1_quad.p00),
        .i_b     (r_s1_quad.p01),
        .i_w     (r_s1_frac.fx),
        .o_valid (w_top_valid),
        .o_res   (w_top)
    );

    lerp_stage #(.W(DATA_Width), .F(FRAC_Width)) u_lerp_bot (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_valid (r_s1_valid),
        .i_a     (r_s1_quad.p10),
        .i_b     (r_s1_quad.p11),
        .i_w     (r_s1_frac.fx),
        .o_valid (w_bot_valid),
        .o_res   (w_bot)
    );

    assign w_s2_valid = w_top_valid & w_bot_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_fy  <= '0;
            r_s2_oob <= 1'b0;
            r_s3_oob <= 1'b0;
        end else if (en) begin
            r_s2_fy  <= r_s1_frac.fy;
            r_s2_oob <= r_s1_oob;
            r_s3_oob <= r_s2_oob;
        end
    end

    lerp_stage #(.W(HW), .F(FRAC_Width)) u_lerp_vert (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_valid (w_s2_valid),
        .i_a     (w_top),
        .i_b     (w_bot),
        .i_w     (r_s2_fy),
        .o_valid (w_s3_valid),
        .o_res   (w_acc)
    );

    // Max acc + half still fits ACCW bits, so the shifted result never exceeds the pixel range.
    assign w_rnd = w_acc + ACCW'(ROUND_HALF(FRAC_Width));
    assign w_pix = DATA_Width'(w_rnd >> (2 * FRAC_Width));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
        end else if (en) begin
            r_out_valid <= w_s3_valid;
            if (w_s3_valid)
                r_out_pixel <= r_s3_oob ? DATA_Width'(BG_VALUE) : w_pix;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;

endmodule

// File: tb/tb_bilinear_interp.sv
// Randomised and directed checks of bilinear_interp against a weighted-sum
// reference model with a due-cycle scoreboard.
module tb_bilinear_interp;

    localparam int BG = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_oob = 1'b0;
    logic [7:0] p00 = '0, p01 = '0, p10 = '0, p11 = '0;
    logic [3:0] frac_x = '0, frac_y = '0;
    logic       out_valid;
    logic [7:0] out_pixel;

    bilinear_interp #(.DATA_Width(8), .FRAC_Width(4), .BG_VALUE(BG)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_oob    (in_oob),
        .p00       (p00),
        .p01       (p01),
        .p10       (p10),
        .p11       (p11),
        .frac_x    (frac_x),
        .frac_y    (frac_y),
        .out_valid (out_valid),
        .out_pixel (out_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   en_cnt = 0;
    int   n_out = 0;
    bit   m_v = 0;
    int   m_p = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each corner weighted by the area of the opposite sub-rectangle.
    function automatic int model(input int a, b, c, d, fx, fy, input bit oob);
        int sum;
        if (oob) return BG;
        sum = a * (16 - fx) * (16 - fy) + b * fx * (16 - fy)
            + c * (16 - fx) * fy + d * fx * fy;
        return (sum + 128) / 256;
    endfunction

    task automatic drive(input bit v, input bit oob, input int a, b, c, d, fx, fy);
        in_valid = v;
        in_oob   = oob;
        p00 = 8'(a); p01 = 8'(b); p10 = 8'(c); p11 = 8'(d);
        frac_x = 4'(fx); frac_y = 4'(fy);
    endtask

    task automatic idle();
        drive(0, 0, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    task automatic tick();
        bit exp_v;
        @(posedge clk);
        if (!rst) begin
            sbq.delete();
            m_v = 0;
            m_p = 0;
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_pixel", out_pixel, 0);
        end else if (!en) begin
            #1;
            chk("frz_valid", out_valid, m_v);
            if (m_v) chk("frz_pixel", out_pixel, m_p);
        end else begin
            en_cnt++;
            if (in_valid)
                sbq.push_back('{due: en_cnt + 3,
                                val: model(p00, p01, p10, p11, frac_x, frac_y, in_oob)});
            #1;
            exp_v = (sbq.size() > 0) && (sbq[0].due == en_cnt);
            chk("valid", out_valid, exp_v);
            m_v = exp_v;
            if (exp_v) begin
                chk("pixel", out_pixel, sbq[0].val);
                m_p = sbq[0].val;
                n_out++;
                sbq.pop_front();
            end
        end
    endtask

    initial begin
        int base;

        // Reset held for 3 cycles
        rst = 0; en = 1; idle();
        repeat (3) tick();
        rst = 1;

        // Single sample, 4-cycle latency
        drive(1, 0, 100, 100, 100, 100, 5, 9);
        tick();
        idle();
        repeat (6) tick();

        // Half rounds up, corner weights, identity at zero fraction
        drive(1, 0, 0, 255, 0, 255, 8, 0);  tick();
        drive(1, 0, 0, 0, 0, 255, 15, 15);  tick();
        drive(1, 0, 37, 200, 90, 11, 0, 0); tick();
        idle();
        repeat (5) tick();

        // Out-of-bounds in the middle of three back-to-back samples
        base = n_out;
        drive(1, 0, 10, 20, 30, 40, 3, 7);       tick();
        drive(1, 1, 250, 250, 250, 250, 15, 15); tick();
        drive(1, 0, 200, 5, 60, 120, 12, 2);     tick();
        idle();
        repeat (5) tick();
        chk("oob_count", n_out - base, 3);

        // Six samples with a 3-cycle stall in the middle
        base = n_out;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                en = 0;
                repeat (3) begin
                    drive(1, 0, $urandom_range(0, 255), 0, 0, 0, 1, 1);
                    tick();
                end
                en = 1;
            end
            drive(1, 0, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
        end
        idle();
        repeat (6) tick();
        chk("stall_count", n_out - base, 6);

        // Random traffic with random stalls, bubbles and oob
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
        end
        en = 1;
        idle();
        repeat (6) tick();

        // Reset with three samples in flight: none may emerge
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 50 + i, 60, 70, 80, 4, 4);
            tick();
        end
        rst = 0;
        idle();
        tick();
        rst = 1;
        repeat (8) tick();
        chk("rst_flush_count", n_out - base, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
